// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that merges NREQ requesters into one FIFO write port, BURST_LEN words per grant.
// Grant is registered one cycle after valid; writes stall on full. Optional FIFO_ARB_STATS_EN adds per-requester write counters.
`ifndef WIDTH
`define WIDTH 8
`endif

module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int BURST_LEN = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*`WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     w_en,
  output logic [`WIDTH-1:0]        data_in,
  input  logic                     full,
  output logic [NREQ-1:0]          grant,
  output logic                     busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0]       wr_cnt
`endif
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic {IDLE, XFER} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] owner;
  logic [IW-1:0] last_owner;
  logic [IW-1:0] pick;
  logic          pick_vld;
  logic [4:0]    beat;
  logic          done;

  // Descending scan so the nearest set bit after last_owner is the one that sticks.
  always_comb begin
    int idx;
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last_owner) + k) % NREQ;
      if (req_valid[idx]) begin
        pick     = IW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    w_en      = 1'b0;
    data_in   = '0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld) state_nxt = XFER;
      end
      XFER: begin
        req_ready[owner] = ~full;
        w_en             = req_valid[owner] & ~full;
        data_in          = req_data[int'(owner)*`WIDTH +: `WIDTH];
        done             = ~req_valid[owner] | (w_en & (beat == 5'(BURST_LEN - 1)));
        if (done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      owner      <= '0;
      last_owner <= IW'(NREQ - 1);
      beat       <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant <= NREQ'(1) << pick;
            owner <= pick;
            beat  <= '0;
          end
        end
        XFER: begin
          if (w_en) beat <= beat + 5'd1;
          if (done) begin
            grant      <= '0;
            last_owner <= owner;
          end
        end
        default: grant <= '0;
      endcase
    end
  end

  assign busy = (state == XFER);

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] cnt [NREQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (w_en && owner == IW'(i) && cnt[i] != 16'hFFFF) cnt[i] <= cnt[i] + 16'd1;
      end
    end
  end

  always_comb begin
    wr_cnt = '0;
    for (int i = 0; i < NREQ; i++) wr_cnt[i*16 +: 16] = cnt[i];
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: a queue/count model predicts grant, ready, write enable and data every cycle;
// directed scenarios pin the model with literal grant orders, burst lengths and FIFO contents.
`ifndef WIDTH
`define WIDTH 8
`endif

module tb_fifo_wr_arbiter;
  localparam int NREQ = 4;
  localparam int BL   = 4;
  localparam int W    = `WIDTH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*W-1:0]   req_data;
  logic [NREQ-1:0]     req_ready;
  logic                w_en;
  logic [W-1:0]        data_in;
  logic                full;
  logic [NREQ-1:0]     grant;
  logic                busy;
`ifdef FIFO_ARB_STATS_EN
  logic [NREQ*16-1:0]  wr_cnt;
`endif

  fifo_wr_arbiter #(.NREQ(NREQ), .BURST_LEN(BL)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .w_en(w_en), .data_in(data_in), .full(full),
    .grant(grant), .busy(busy)
`ifdef FIFO_ARB_STATS_EN
    , .wr_cnt(wr_cnt)
`endif
  );

  // Words offered (tot, set by stimulus) and words consumed (used, advanced by the model).
  int tot [NREQ];
  int used [NREQ];
  int m_wr [NREQ];
  int m_owner = -1;
  int m_last  = NREQ - 1;
  int m_beats = 0;
  int gseq [$];
  int bseq [$];
  logic [W-1:0] fifo_q [$];
  int nchk = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  function automatic int rr_pick(int last, logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_iq(string nm, int act[$], int exp[$]);
    chk({nm, "_len"}, act.size(), exp.size());
    for (int i = 0; i < exp.size() && i < act.size(); i++) chk(nm, act[i], exp[i]);
  endtask

  task automatic chk_fifo(int who, int n);
    chk("fifo_len", fifo_q.size(), n);
    for (int k = 0; k < n && k < fifo_q.size(); k++) chk("fifo_word", fifo_q[k], (who << 4) | k);
  endtask

  logic            e_wen;
  logic            e_busy;
  logic [NREQ-1:0] e_ready;
  logic [NREQ-1:0] e_grant;
  logic [W-1:0]    e_data;

  always_comb begin
    e_wen   = 1'b0;
    e_busy  = 1'b0;
    e_ready = '0;
    e_grant = '0;
    e_data  = '0;
    if (rst_n === 1'b1 && m_owner >= 0) begin
      e_busy           = 1'b1;
      e_grant[m_owner] = 1'b1;
      e_ready[m_owner] = !full;
      e_wen            = req_valid[m_owner] && !full;
      e_data           = req_data[m_owner*W +: W];
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= -1;
      m_last  <= NREQ - 1;
      m_beats <= 0;
      for (int i = 0; i < NREQ; i++) begin
        used[i] <= 0;
        m_wr[i] <= 0;
      end
    end else begin
      if (w_en === 1'b1) fifo_q.push_back(data_in);
      if (m_owner < 0) begin
        if (req_valid != 0) begin
          m_owner <= rr_pick(m_last, req_valid);
          m_beats <= 0;
          gseq.push_back(rr_pick(m_last, req_valid));
        end
      end else begin
        if (e_wen) begin
          used[m_owner] <= used[m_owner] + 1;
          if (m_wr[m_owner] < 65535) m_wr[m_owner] <= m_wr[m_owner] + 1;
        end
        if (!req_valid[m_owner] || (e_wen && m_beats + 1 == BL)) begin
          bseq.push_back(m_beats + (e_wen ? 1 : 0));
          m_last  <= m_owner;
          m_owner <= -1;
        end else if (e_wen) begin
          m_beats <= m_beats + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("grant", grant, e_grant);
      chk("busy", busy, e_busy);
      chk("req_ready", req_ready, e_ready);
      chk("w_en", w_en, e_wen);
      chk("data_in", data_in, e_data);
`ifdef FIFO_ARB_STATS_EN
      for (int i = 0; i < NREQ; i++) chk("wr_cnt", wr_cnt[i*16 +: 16], m_wr[i]);
`endif
    end
  end

  task automatic apply();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]        = (used[i] < tot[i]);
      req_data[i*W +: W]  = W'((i << 4) | (used[i] & 15));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    apply();
  endtask

  task automatic do_reset();
    for (int i = 0; i < NREQ; i++) tot[i] = 0;
    full = 1'b0;
    apply();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    gseq.delete();
    bseq.delete();
    fifo_q.delete();
    tick();
  endtask

  initial begin
    int e[$];
    int eb[$];
    rst_n = 1'b0;
    full  = 1'b0;
    for (int i = 0; i < NREQ; i++) tot[i] = 0;
    apply();
    tick();
    tick();
    chk_en = 1'b1;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_w_en", w_en, 0);
    rst_n = 1'b1;
    gseq.delete();
    bseq.delete();
    fifo_q.delete();
    tick();

    // Single requester, 6 words: burst of 4, one idle cycle, burst of 2.
    tot[0] = 6;
    apply();
    tick();
    chk("first_grant", grant, 4'b0001);
    repeat (13) tick();
    e = '{0, 0};
    chk_iq("t1_grants", gseq, e);
    eb = '{4, 2};
    chk_iq("t1_bursts", bseq, eb);
    chk_fifo(0, 6);

    // All four requesting: strict rotation, full bursts.
    do_reset();
    tot[0] = 8; tot[1] = 4; tot[2] = 4; tot[3] = 4;
    apply();
    repeat (30) tick();
    e = '{0, 1, 2, 3, 0};
    chk_iq("t2_grants", gseq, e);
    eb = '{4, 4, 4, 4, 4};
    chk_iq("t2_bursts", bseq, eb);
    chk("t2_words", fifo_q.size(), 20);

    // FIFO full for 3 cycles mid-burst.
    do_reset();
    tot[0] = 4;
    apply();
    repeat (3) tick();
    full = 1'b1;
    #1;
    chk("stall_w_en", w_en, 0);
    chk("stall_ready", req_ready, 0);
    chk("stall_grant", grant, 4'b0001);
    repeat (3) tick();
    chk("stall_words", fifo_q.size(), 2);
    chk("stall_grant_held", grant, 4'b0001);
    full = 1'b0;
    repeat (8) tick();
    eb = '{4};
    chk_iq("t3_bursts", bseq, eb);
    chk_fifo(0, 4);

    // Owner 2 runs dry after 2 words; requester 1 appears mid-burst and waits its turn.
    do_reset();
    tot[2] = 2; tot[3] = 3;
    apply();
    repeat (2) tick();
    tot[1] = 1;
    apply();
    chk("nonowner_ready", req_ready[1], 0);
    repeat (16) tick();
    e = '{2, 3, 1};
    chk_iq("t4_grants", gseq, e);
    eb = '{2, 3, 1};
    chk_iq("t4_bursts", bseq, eb);

    // Reset pulsed mid-burst.
    do_reset();
    tot[0] = 4;
    apply();
    repeat (3) tick();
    chk("pre_rst_w_en", w_en, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_w_en", w_en, 0);
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_data", data_in, 0);
    tick();
    tick();
    gseq.delete();
    bseq.delete();
    fifo_q.delete();
    tot[0] = 4; tot[1] = 1; tot[2] = 1; tot[3] = 1;
    apply();
    rst_n = 1'b1;
    #1;
    chk("post_rst_no_grant", grant, 0);
    tick();
    chk("post_rst_grant", grant, 4'b0001);
    repeat (25) tick();
    e = '{0, 1, 2, 3};
    chk_iq("t5_grants", gseq, e);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter: NREQ, 4, number of write requesters (2..8).
REQ-002 Parameter: BURST_LEN, 4, maximum writes per grant (1..16).
REQ-003 Data width SHALL be the global `WIDTH macro.
REQ-004 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-005 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port: req_valid  input  NREQ  requester i has a word to write.
REQ-007 Port: req_data  input  NREQ*`WIDTH  requester i word at bits [i*`WIDTH +: `WIDTH].
REQ-008 Port: req_ready  output  NREQ  requester i word accepted this cycle when req_valid[i] & req_ready[i].
REQ-009 Port: w_en  output  1  FIFO write enable.
REQ-010 Port: data_in  output  `WIDTH  FIFO write data.
REQ-011 Port: full  input  1  FIFO full flag.
REQ-012 Port: grant  output  NREQ  registered one-hot current owner; all zero when idle.
REQ-013 Port: busy  output  1  high while in XFER.

Function
REQ-014 FSM SHALL have two states: IDLE and XFER.
REQ-015 IDLE: if any req_valid bit is set, the arbiter SHALL select the first set bit searching round-robin from (last_owner+1) mod NREQ, register it in grant and enter XFER at the next edge.
REQ-016 IDLE: req_ready, w_en SHALL be 0; grant-to-first-write latency is exactly 1 cycle.
REQ-017 XFER: req_ready[owner] SHALL equal ~full; all other req_ready bits SHALL be 0.
REQ-018 XFER: w_en SHALL equal req_valid[owner] & ~full, combinational; data_in SHALL equal req_data[owner].
REQ-019 IDLE: data_in SHALL be 0.
REQ-020 A 5-bit beat counter SHALL increment on every cycle with w_en=1 and clear on entry to XFER.
REQ-021 XFER SHALL return to IDLE, clearing grant and updating last_owner, when the write that brings the beat count to BURST_LEN occurs, or in any cycle where req_valid[owner]=0.
REQ-022 While full=1 with req_valid[owner]=1, the owner SHALL keep the grant; stall cycles SHALL not increment the beat counter.
REQ-023 No word SHALL be written when full=1, and no word SHALL be dropped or duplicated.
REQ-024 Any requester with req_valid held high SHALL be granted within NREQ arbitration rounds (no starvation).
REQ-025 Changes of req_valid on non-owner lines during XFER SHALL have no effect until the next IDLE.

Reset
REQ-026 On rst_n low, asynchronously: state=IDLE, grant=0, busy=0, beat counter=0, last_owner=NREQ-1 (requester 0 wins first).
REQ-027 w_en, req_ready and data_in SHALL be 0 while rst_n is low, including reset asserted mid-burst.
REQ-028 After rst_n deasserts, first grant SHALL occur no earlier than the first posedge with rst_n high.

Configuration
REQ-029 Macro FIFO_ARB_STATS_EN SHALL, when defined, add output wr_cnt (NREQ*16 bits), counter i at [i*16 +: 16], incrementing on each write by requester i, saturating at 16'hFFFF, reset to 0.
REQ-030 Without FIFO_ARB_STATS_EN, port wr_cnt and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-031 Reset, then req_valid=4'b0001 with 6 words, full=0 -> grant=0001 one cycle later; 4 writes, 1 IDLE cycle, regrant, 2 writes; FIFO contents in order.
REQ-032 req_valid=4'b1111 held, full=0 -> grant sequence 0001,0010,0100,1000,0001; each burst exactly 4 writes.
REQ-033 Owner writing, full=1 for 3 cycles mid-burst -> w_en=0, req_ready=0, grant held, beat count frozen; burst completes with 4 total writes after full drops.
REQ-034 Owner 2 drops req_valid after 2 writes -> IDLE next edge; next grant goes to requester 3 if valid, else search wraps.
REQ-035 rst_n pulsed low mid-burst -> w_en, grant, busy 0 immediately; after release, requester 0 granted first.
REQ-036 With FIFO_ARB_STATS_EN: 70000 writes by requester 1 -> wr_cnt[31:16]=16'hFFFF, others 0; without macro, build has no wr_cnt port.
